// File: rtl/conv_out_writer_pkg.sv
// Shared constants and pixel helpers for the conv output writer.
// Defaults match the 28-wide input map producing a 26x26 valid-conv output.
package conv_out_writer_pkg;

  localparam int FMAP_STRIDE    = 28;
  localparam int ADDR_LEN_DEF   = 9;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int OUT_COUNT_DEF  = 676;
  localparam int PIXEL_W        = 8;

  function automatic logic signed [7:0] relu8(input logic signed [7:0] v, input logic en);
    return (en && (v < 0)) ? 8'sd0 : v;
  endfunction

endpackage

// File: rtl/conv_out_writer_sync_fifo.sv
// Small synchronous FIFO; head entry is read straight from storage so the
// consumer sees it the cycle after it is written into an empty FIFO.
module conv_out_writer_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/conv_out_writer.sv
// Buffers finished conv pixels (with optional ReLU) and drains them to the
// output feature-map RAM, pulsing frame_done once per complete output map.
module conv_out_writer
  import conv_out_writer_pkg::*;
#(
  parameter int ADDR_LEN   = ADDR_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RELU       = 1,
  parameter int OUT_COUNT  = OUT_COUNT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          acc_enable,
  input  logic                          flush_acc,
  input  logic signed [7:0]             result,
  input  logic [ADDR_LEN:0]             addr,
  input  logic                          mem_ready,
  output logic                          mem_we,
  output logic [ADDR_LEN:0]             mem_addr,
  output logic signed [7:0]             mem_data,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int ENTRY_W = PIXEL_W + ADDR_LEN + 1;
  localparam int CNT_W   = $clog2(OUT_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_COUNT - 1);

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   write_cnt;

  assign push     = flush_acc && !acc_enable;
  assign wr_entry = {relu8(result, RELU != 0), addr};
  assign mem_we   = !empty;
  assign pop      = mem_we && mem_ready;
  assign mem_data = head[ENTRY_W-1 -: PIXEL_W];
  assign mem_addr = head[ADDR_LEN:0];

  conv_out_writer_sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fill_level)
  );

  // A capture lost to a full FIFO is remembered until the next reset.
  always_ff @(posedge clk) begin
    if (!rst) overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      write_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) begin
        if (write_cnt == LAST_CNT) begin
          write_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          write_cnt <= write_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_out_writer.sv
// Scoreboard bench: a RELU=1 full-size writer and a RELU=0, 4-pixel-frame
// writer share one stimulus stream; expected writes are queued at capture.
module tb_conv_out_writer;

  typedef struct packed {
    logic [9:0]        a;
    logic signed [7:0] d;
  } pix_t;

  logic              clk;
  logic              rst;
  logic              acc_enable;
  logic              flush_acc;
  logic signed [7:0] result;
  logic [9:0]        addr;
  logic              mem_ready;

  logic              mem_we,      alt_mem_we;
  logic [9:0]        mem_addr,    alt_mem_addr;
  logic signed [7:0] mem_data,    alt_mem_data;
  logic [2:0]        fill_level,  alt_fill_level;
  logic              overflow,    alt_overflow;
  logic              frame_done,  alt_frame_done;

  pix_t expDef[$];
  pix_t expAlt[$];
  int   testsRun;
  int   testsFailed;

  conv_out_writer u_dut (
    .clk(clk), .rst(rst), .acc_enable(acc_enable), .flush_acc(flush_acc),
    .result(result), .addr(addr), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .fill_level(fill_level), .overflow(overflow), .frame_done(frame_done)
  );

  conv_out_writer #(.RELU(0), .OUT_COUNT(4)) u_alt (
    .clk(clk), .rst(rst), .acc_enable(acc_enable), .flush_acc(flush_acc),
    .result(result), .addr(addr), .mem_ready(mem_ready),
    .mem_we(alt_mem_we), .mem_addr(alt_mem_addr), .mem_data(alt_mem_data),
    .fill_level(alt_fill_level), .overflow(alt_overflow), .frame_done(alt_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; flush_acc = 1'b0; acc_enable = 1'b0; mem_ready = 1'b0;
    result = '0; addr = '0;
    tick(); tick();
    rst = 1'b1;
    expDef.delete();
    expAlt.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    flush_acc = 1'b1; result = 8'sd33; addr = 10'd7;
    tick();
    rst = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    testsRun++;
    if ({mem_we, mem_addr, mem_data, fill_level, overflow, frame_done} !== 24'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: we=%b addr=%0d data=%0d fill=%0d ovf=%b done=%b, required all 0",
               mem_we, mem_addr, mem_data, fill_level, overflow, frame_done);
    end
    flush_acc = 1'b0; rst = 1'b1;
    tick();
    testsRun++;
    if (mem_we !== 1'b0 || fill_level !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_release: we=%b fill=%0d, required we=0 fill=0", mem_we, fill_level);
    end
  endtask

  task automatic test_single();
    pix_t e;
    do_reset();
    tick();
    result = -8'sd5; addr = 10'd57; flush_acc = 1'b1; mem_ready = 1'b1;
    expDef.push_back('{a: 10'd57, d: 8'sd0});
    expAlt.push_back('{a: 10'd57, d: -8'sd5});
    tick();
    flush_acc = 1'b0;
    testsRun++;
    if (mem_we !== 1'b1 || alt_mem_we !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL single_we: we=%b alt_we=%b, required 1/1", mem_we, alt_mem_we);
    end
    e = expDef.pop_front();
    testsRun++;
    if (mem_addr !== e.a || mem_data !== e.d) begin
      testsFailed++;
      $display("[TB] FAIL single_relu: addr=%0d data=%0d, required addr=%0d data=%0d", mem_addr, mem_data, e.a, e.d);
    end
    e = expAlt.pop_front();
    testsRun++;
    if (alt_mem_addr !== e.a || alt_mem_data !== e.d) begin
      testsFailed++;
      $display("[TB] FAIL single_norelu: addr=%0d data=%0d, required addr=%0d data=%0d", alt_mem_addr, alt_mem_data, e.a, e.d);
    end
    tick();
    testsRun++;
    if (mem_we !== 1'b0 || fill_level !== 3'd0 || alt_fill_level !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL single_pop: we=%b fill=%0d alt_fill=%0d, required 0/0/0", mem_we, fill_level, alt_fill_level);
    end
  endtask

  task automatic test_backpressure();
    pix_t e;
    int commits;
    do_reset();
    tick();
    for (int v = 1; v <= 5; v++) begin
      result = 8'(v); addr = 10'(100 + v); flush_acc = 1'b1;
      if (v <= 4) expDef.push_back('{a: 10'(100 + v), d: 8'(v)});
      tick();
    end
    flush_acc = 1'b0;
    testsRun++;
    if (fill_level !== 3'd4 || overflow !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL bp_full: fill=%0d ovf=%b, required fill=4 ovf=1", fill_level, overflow);
    end
    mem_ready = 1'b1;
    commits = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_we) begin
        commits++;
        testsRun++;
        if (expDef.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL bp_extra: write addr=%0d data=%0d, required none", mem_addr, mem_data);
        end else begin
          e = expDef.pop_front();
          if (mem_addr !== e.a || mem_data !== e.d) begin
            testsFailed++;
            $display("[TB] FAIL bp_order: addr=%0d data=%0d, required addr=%0d data=%0d", mem_addr, mem_data, e.a, e.d);
          end
        end
      end
      tick();
    end
    testsRun++;
    if (commits != 4 || overflow !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL bp_count: writes=%0d ovf=%b, required writes=4 ovf=1", commits, overflow);
    end
  endtask

  task automatic test_full_pop();
    pix_t e;
    do_reset();
    tick();
    for (int v = 10; v <= 13; v++) begin
      result = 8'(v); addr = 10'(v); flush_acc = 1'b1;
      expDef.push_back('{a: 10'(v), d: 8'(v)});
      tick();
    end
    testsRun++;
    if (fill_level !== 3'd4 || overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fp_prefill: fill=%0d ovf=%b, required fill=4 ovf=0", fill_level, overflow);
    end
    result = 8'sd14; addr = 10'd14; mem_ready = 1'b1;
    e = expDef.pop_front();
    testsRun++;
    if (mem_addr !== e.a || mem_data !== e.d) begin
      testsFailed++;
      $display("[TB] FAIL fp_head: addr=%0d data=%0d, required addr=%0d data=%0d", mem_addr, mem_data, e.a, e.d);
    end
    expDef.push_back('{a: 10'd14, d: 8'sd14});
    tick();
    flush_acc = 1'b0;
    testsRun++;
    if (fill_level !== 3'd4 || overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fp_same: fill=%0d ovf=%b, required fill=4 ovf=0", fill_level, overflow);
    end
    for (int c = 0; c < 8; c++) begin
      if (mem_we && expDef.size() != 0) begin
        e = expDef.pop_front();
        testsRun++;
        if (mem_addr !== e.a || mem_data !== e.d) begin
          testsFailed++;
          $display("[TB] FAIL fp_drain: addr=%0d data=%0d, required addr=%0d data=%0d", mem_addr, mem_data, e.a, e.d);
        end
      end
      tick();
    end
    testsRun++;
    if (expDef.size() != 0 || mem_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fp_empty: left=%0d we=%b, required 0/0", expDef.size(), mem_we);
    end
  endtask

  task automatic test_gating();
    do_reset();
    tick();
    acc_enable = 1'b1; flush_acc = 1'b1; result = 8'sd9; addr = 10'd3;
    tick(); tick(); tick();
    testsRun++;
    if (fill_level !== 3'd0 || mem_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL gate_block: fill=%0d we=%b, required 0/0", fill_level, mem_we);
    end
    acc_enable = 1'b0;
    tick();
    flush_acc = 1'b0;
    testsRun++;
    if (fill_level !== 3'd1 || mem_data !== 8'sd9 || mem_addr !== 10'd3) begin
      testsFailed++;
      $display("[TB] FAIL gate_open: fill=%0d data=%0d addr=%0d, required 1/9/3", fill_level, mem_data, mem_addr);
    end
  endtask

  task automatic test_frame();
    pix_t e;
    int   commits;
    int   pulses;
    logic wasWe;
    logic expDone;
    do_reset();
    tick();
    mem_ready = 1'b1;
    commits = 0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      wasWe = alt_mem_we;
      if (wasWe) begin
        testsRun++;
        if (expAlt.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL frame_extra: write addr=%0d, required none", alt_mem_addr);
        end else begin
          e = expAlt.pop_front();
          if (alt_mem_addr !== e.a || alt_mem_data !== e.d) begin
            testsFailed++;
            $display("[TB] FAIL frame_data: addr=%0d data=%0d, required addr=%0d data=%0d",
                     alt_mem_addr, alt_mem_data, e.a, e.d);
          end
        end
      end
      if (i < 9) begin
        flush_acc = 1'b1; result = 8'(20 + i); addr = 10'(200 + i);
        expAlt.push_back('{a: 10'(200 + i), d: 8'(20 + i)});
      end else begin
        flush_acc = 1'b0;
      end
      tick();
      if (wasWe) commits++;
      expDone = wasWe && (commits % 4 == 0);
      if (alt_frame_done) pulses++;
      testsRun++;
      if (alt_frame_done !== expDone || frame_done !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL frame_done: cycle=%0d commits=%0d done=%b full_done=%b, required done=%b full_done=0",
                 i, commits, alt_frame_done, frame_done, expDone);
      end
    end
    testsRun++;
    if (commits != 9 || pulses != 2) begin
      testsFailed++;
      $display("[TB] FAIL frame_total: writes=%0d pulses=%0d, required writes=9 pulses=2", commits, pulses);
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b0; acc_enable = 1'b0; flush_acc = 1'b0; result = '0; addr = '0; mem_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_full_pop();
    test_gating();
    test_frame();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
